// File: rtl/sparc_pkg.sv
// Shared definitions for the SPARC integer pipeline front end.
// Holds datapath widths, the PC step and the fetch FSM state type.
package sparc_pkg;

    localparam int          INST_W = 32;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs between fetch and decode.
// Synchronous flush; DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed when count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: fetch PC, single outstanding instruction-memory request,
// prefetch FIFO toward decode, and redirect/flush handling.
module instruction_fetch
    import sparc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] instruction,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pending_pc;
    logic              outstanding;
    logic [CW-1:0]     count;
    logic [63:0]       head;
    logic              req_int;
    logic              ack;
    logic              push;
    logic              pop;
    logic              misaligned;
    logic [ADDR_W-1:0] drain_target;

    always_comb begin
        req_int = 1'b0;
        case (state)
            FETCH:   req_int = (count < CW'(FIFO_DEPTH)) || outstanding;
            DRAIN:   req_int = 1'b1;
            default: req_int = 1'b0;
        endcase
    end

    // rst gates the request combinationally so it drops in the reset cycle itself.
    assign imem_req     = req_int && !rst;
    assign imem_addr    = pc;
    assign ack          = imem_ack && imem_req;
    assign misaligned   = redirect_pc[1:0] != 2'b00;
    assign drain_target = redirect ? redirect_pc : pending_pc;

    assign inst_valid   = (count != '0) && !redirect;
    assign pop          = inst_valid && inst_ready;
    assign push         = ack && (state == FETCH) && !redirect;
    assign instruction  = (count != '0) ? head[31:0]  : '0;
    assign inst_pc      = (count != '0) ? head[63:32] : '0;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (64)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({pc, imem_rdata}),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pending_pc  <= RESET_PC;
            outstanding <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            outstanding <= imem_req && !ack;
            if (redirect) fetch_fault <= misaligned;
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if (imem_req && !ack) begin
                            pending_pc <= redirect_pc;
                            state      <= DRAIN;
                        end else begin
                            pc    <= redirect_pc;
                            state <= misaligned ? FAULT : FETCH;
                        end
                    end else if (ack) begin
                        pc <= pc + PC_INC;
                    end
                end
                DRAIN: begin
                    if (redirect) pending_pc <= redirect_pc;
                    if (ack) begin
                        pc    <= drain_target;
                        state <= (drain_target[1:0] != 2'b00) ? FAULT : FETCH;
                    end
                end
                default: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= misaligned ? FAULT : FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run, compared every cycle against a queue-based reference model.
module tb_instruction_fetch;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .instruction (instruction),
        .inst_pc     (inst_pc),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch pc, buffered words, and pending-redirect bookkeeping.
    logic [31:0] m_pc, m_pend;
    logic        m_wait, m_drain, m_fstate, m_fault;
    logic [63:0] m_q[$];

    // Memory responder.
    bit          mem_busy;
    int          mem_left;
    logic [31:0] mem_addr;
    int          lat_fixed;
    bit          lat_rand;

    logic        obs_req, obs_valid, obs_fault;
    logic [31:0] obs_addr, obs_pc;
    logic [31:0] ack_log[$];
    logic [31:0] xfer_log[$];
    int          cyc;
    int          first_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_logs();
        ack_log.delete();
        xfer_log.delete();
        cyc = 0;
        first_valid = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
        m_pc = 32'h0; m_pend = 32'h0;
        m_wait = 0; m_drain = 0; m_fstate = 0; m_fault = 0;
        m_q.delete();
        mem_busy = 0; mem_left = 0;
        clear_logs();
        @(negedge clk);
    endtask

    task automatic cycle(input logic redir, input logic [31:0] rpc, input logic rdy);
        logic exp_req, exp_valid, ack, pop;
        @(negedge clk);
        rst = 1'b0;
        redirect = redir;
        redirect_pc = rpc;
        inst_ready = rdy;
        #1;
        if (imem_req && !mem_busy) begin
            mem_busy = 1;
            mem_addr = imem_addr;
            mem_left = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
        end
        imem_ack = mem_busy && (mem_left == 0);
        imem_rdata = imem_ack ? (mem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
        #1;
        cyc++;

        exp_req   = m_drain ? 1'b1 : m_fstate ? 1'b0 : ((m_q.size() < D) || m_wait);
        exp_valid = (m_q.size() != 0) && !redir;
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            chk("instruction", instruction, m_q[0][31:0]);
            chk("inst_pc", inst_pc, m_q[0][63:32]);
        end
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});

        obs_req = imem_req; obs_addr = imem_addr; obs_valid = inst_valid;
        obs_pc = inst_pc; obs_fault = fetch_fault;
        if (imem_req && imem_ack) ack_log.push_back(imem_addr);
        if (inst_valid && inst_ready) xfer_log.push_back(inst_pc);
        if (inst_valid && first_valid < 0) first_valid = cyc;

        if (imem_ack) mem_busy = 0;
        else if (mem_busy) mem_left--;

        ack = imem_ack && exp_req;
        pop = exp_valid && rdy;
        if (pop) void'(m_q.pop_front());
        if (redir) begin
            m_q.delete();
            m_fault = rpc[1:0] != 2'b00;
        end
        if (m_drain) begin
            if (redir) m_pend = rpc;
            if (ack) begin
                m_drain = 0;
                m_pc = m_pend;
                m_fstate = m_pend[1:0] != 2'b00;
            end
        end else if (m_fstate) begin
            if (redir) begin
                m_pc = rpc;
                m_fstate = rpc[1:0] != 2'b00;
            end
        end else if (redir) begin
            if (exp_req && !ack) begin
                m_drain = 1;
                m_pend = rpc;
            end else begin
                m_pc = rpc;
                m_fstate = rpc[1:0] != 2'b00;
            end
        end else if (ack) begin
            m_q.push_back({m_pc, m_pc ^ 32'hA5A5_0000});
            m_pc = m_pc + 32'd4;
        end
        m_wait = exp_req && !ack;
    endtask

    initial begin
        int found, nreq, nx;
        logic [31:0] rpc;
        lat_rand = 0;
        lat_fixed = 0;

        // Zero-wait streaming after reset.
        do_reset();
        repeat (6) cycle(0, 32'h0, 1);
        chk("p1_ack0", ack_log[0], 32'h0);
        chk("p1_ack1", ack_log[1], 32'h4);
        chk("p1_ack2", ack_log[2], 32'h8);
        chk("p1_ack3", ack_log[3], 32'hC);
        chk("p1_xfer0", xfer_log[0], 32'h0);
        chk("p1_xfer1", xfer_log[1], 32'h4);
        chk("p1_xfer2", xfer_log[2], 32'h8);
        chk("p1_first_valid", first_valid, 32'd2);

        // Decode stalled: FIFO fills, then one pop reopens fetch.
        do_reset();
        repeat (3) cycle(0, 32'h0, 0);
        chk("p2_req_dropped", {31'b0, obs_req}, 32'd0);
        chk("p2_acks", ack_log.size(), 32'd2);
        cycle(0, 32'h0, 1);
        chk("p2_pop_pc", obs_pc, 32'h0);
        cycle(0, 32'h0, 0);
        chk("p2_rereq", {31'b0, obs_req}, 32'd1);
        chk("p2_rereq_addr", obs_addr, 32'h8);

        // Slow memory, redirect while a request is in flight.
        do_reset();
        lat_fixed = 3;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            cycle(0, 32'h0, 1);
            if (obs_req && obs_addr == 32'h4) found = 1;
        end
        chk("p3_req4_seen", found, 32'd1);
        clear_logs();
        cycle(1, 32'h100, 1);
        repeat (14) cycle(0, 32'h0, 1);
        chk("p3_drop_ack", ack_log[0], 32'h4);
        chk("p3_next_ack", ack_log[1], 32'h100);
        chk("p3_first_xfer", xfer_log[0], 32'h100);

        // Redirect coinciding with ack and a would-be pop.
        do_reset();
        lat_fixed = 0;
        repeat (5) cycle(0, 32'h0, 1);
        nx = xfer_log.size();
        cycle(1, 32'h200, 1);
        chk("p4_no_valid", {31'b0, obs_valid}, 32'd0);
        chk("p4_no_xfer", xfer_log.size(), nx);
        cycle(0, 32'h0, 1);
        chk("p4_empty", {31'b0, obs_valid}, 32'd0);
        chk("p4_addr", obs_addr, 32'h200);

        // Misaligned redirect faults and stops fetching until an aligned one.
        cycle(1, 32'h203, 1);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 32'h0, 1);
            nreq += int'(obs_req);
            chk("p5_fault_on", {31'b0, obs_fault}, 32'd1);
        end
        chk("p5_no_reqs", nreq, 32'd0);
        cycle(1, 32'h300, 1);
        cycle(0, 32'h0, 1);
        chk("p5_fault_clr", {31'b0, obs_fault}, 32'd0);
        chk("p5_addr", obs_addr, 32'h300);

        // PC wraps past the top of the address space.
        cycle(1, 32'hFFFF_FFFC, 1);
        cycle(0, 32'h0, 1);
        chk("p6_top", obs_addr, 32'hFFFF_FFFC);
        cycle(0, 32'h0, 1);
        chk("p6_wrap", obs_addr, 32'h0);

        // Randomized traffic, then reset mid-run.
        lat_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            cycle($urandom_range(0, 24) == 0, rpc, $urandom_range(0, 3) != 0);
        end
        do_reset();
        for (int i = 0; i < 200; i++) begin
            rpc = $urandom & 32'hFFFF_FFFC;
            cycle($urandom_range(0, 30) == 0, rpc, $urandom_range(0, 1) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
